axi4_mem_slave: RTL and testbench

AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_mem_ram.sv | 23 ++
 rtl/axi4_mem_slave.sv | 131 +++++++++++++
 tb/tb_axi4_mem_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes, FSM state types and the INCR burst legality check
package axi_pkg;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [2:0] BEAT_SIZE = 3'd2;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic burst_bad(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input int unsigned depth);
    logic [31:0] beats;
    beats = 32'(len) + 32'd1;
    return size != BEAT_SIZE || addr[1:0] != 2'b00 || (addr >> 2) + beats > depth || 32'(addr[11:0]) + (beats << 2) > 32'h1000;
  endfunction
endpackage

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: word memory with byte-enable synchronous write and synchronous read
module axi_mem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 INCR-burst memory slave with independent read and write FSMs
module axi4_mem_slave import axi_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int MAW = $clog2(MEM_DEPTH);
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [MAW-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
  logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic w_bad_q, w_bad_d, w_err_q, w_err_d, r_bad_q, r_bad_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last, r_last;
  logic [31:0] ram_rdata;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign b_hs = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs = RVALID && RREADY;
  assign w_last = w_cnt_q == w_len_q;
  assign r_last = r_cnt_q == r_len_q;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      w_cnt_q <= '0;
      r_cnt_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_cnt_q <= w_cnt_d;
      r_cnt_q <= r_cnt_d;
    end
    w_addr_q <= w_addr_d;
    w_len_q <= w_len_d;
    w_bad_q <= w_bad_d;
    w_err_q <= w_err_d;
    r_addr_q <= r_addr_d;
    r_len_q <= r_len_d;
    r_bad_q <= r_bad_d;
  end
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d = w_addr_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    w_bad_d = w_bad_q;
    w_err_d = w_err_q;
    if (aw_hs) begin
      w_state_d = W_DATA;
      w_addr_d = AWADDR[MAW+1:2];
      w_len_d = AWLEN;
      w_cnt_d = '0;
      w_bad_d = burst_bad(32'(AWADDR), AWLEN, AWSIZE, MEM_DEPTH);
      w_err_d = 1'b0;
    end
    if (w_hs) begin
      w_addr_d = w_addr_q + 1'b1;
      w_cnt_d = w_cnt_q + 1'b1;
      w_err_d = w_err_q || (WLAST != w_last);
      w_state_d = w_last ? W_RESP : W_DATA;
    end
    if (b_hs) w_state_d = W_IDLE;
  end
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d = r_addr_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q;
    r_bad_d = r_bad_q;
    if (ar_hs) begin
      r_state_d = R_DATA;
      r_addr_d = ARADDR[MAW+1:2];
      r_len_d = ARLEN;
      r_cnt_d = '0;
      r_bad_d = burst_bad(32'(ARADDR), ARLEN, ARSIZE, MEM_DEPTH);
    end
    if (r_hs) begin
      r_state_d = r_last ? R_IDLE : R_DATA;
      r_addr_d = r_last ? r_addr_q : r_addr_q + 1'b1;
      r_cnt_d = r_last ? r_cnt_q : r_cnt_q + 1'b1;
    end
  end
  always_comb begin
    AWREADY = !ARESET && w_state_q == W_IDLE;
    WREADY = !ARESET && w_state_q == W_DATA;
    BVALID = !ARESET && w_state_q == W_RESP;
    BRESP = BVALID && (w_bad_q || w_err_q) ? SLVERR : OKAY;
    ARREADY = !ARESET && r_state_q == R_IDLE;
    RVALID = !ARESET && r_state_q == R_DATA;
    RLAST = RVALID && r_last;
    RRESP = RVALID && r_bad_q ? SLVERR : OKAY;
    RDATA = RVALID && !r_bad_q ? ram_rdata : '0;
  end
  axi_mem_ram #(.DEPTH(MEM_DEPTH)) u_ram (
    .clk(ACLK),
    .we(w_hs && !w_bad_q),
    .waddr(w_addr_q),
    .wstrb(WSTRB),
    .wdata(WDATA),
    .re(ar_hs || r_hs),
    .raddr(r_addr_d),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: vector table of bursts plus hand sequences, reads checked through a scoreboard queue
module tb_axi4_mem_slave;
  logic ACLK, ARESET;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;

  axi4_mem_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit wr;
    logic [15:0] a;
    logic [7:0] len;
    logic [2:0] sz;
    logic [31:0] d0;
    logic [31:0] step;
    logic [3:0] st;
    int wl;
    int stall_b;
    int stall_n;
    logic [1:0] resp;
    string nm;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0] r;
    logic l;
  } beat_t;

  vec_t tv[$];
  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    return w == 0 ? AWREADY : w == 1 ? WREADY : w == 2 ? ARREADY : BVALID;
  endfunction

  task automatic wait_sig(input int w, input string nm);
    int n = 0;
    while (!sig(w) && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (!sig(w)) begin
      checks++;
      errors++;
      $display("FAIL %s: handshake timeout got 0 expected 1", nm);
    end
  endtask

  task automatic add(input bit wr, input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                     input logic [31:0] d0, input logic [31:0] step, input logic [3:0] st, input int wl,
                     input int stall_b, input int stall_n, input logic [1:0] resp, input string nm);
    vec_t v;
    v = '{wr, a, len, sz, d0, step, st, wl, stall_b, stall_n, resp, nm};
    tv.push_back(v);
  endtask

  task automatic get_b(input logic [1:0] exp, input string nm);
    wait_sig(3, nm);
    chk({nm, "_bresp"}, 64'(BRESP), 64'(exp));
    @(negedge ACLK);
    chk({nm, "_bhold"}, 64'({BVALID, BRESP}), 64'({1'b1, exp}));
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk({nm, "_bdone"}, 64'({BVALID, AWREADY}), 64'(2'b01));
  endtask

  task automatic chk_beat(input string nm);
    beat_t e;
    chk({nm, "_rvalid"}, 64'(RVALID), 64'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected beat got %h expected none", nm, RDATA);
    end else begin
      e = sb.pop_front();
      chk({nm, "_rdata"}, 64'(RDATA), 64'(e.d));
      chk({nm, "_rresp"}, 64'(RRESP), 64'(e.r));
      chk({nm, "_rlast"}, 64'(RLAST), 64'(e.l));
    end
  endtask

  task automatic axi_write(input vec_t v);
    @(negedge ACLK);
    AWADDR = v.a; AWLEN = v.len; AWSIZE = v.sz; AWVALID = 1'b1;
    wait_sig(0, v.nm);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      WDATA = v.d0 + v.step * 32'(i); WSTRB = v.st; WLAST = (i == v.wl); WVALID = 1'b1;
      wait_sig(1, v.nm);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk({v.nm, "_bvalid_next"}, 64'(BVALID), 64'(1));
    get_b(v.resp, v.nm);
  endtask

  task automatic axi_read(input vec_t v);
    for (int i = 0; i <= int'(v.len); i++) begin
      beat_t b;
      b = '{v.d0 + v.step * 32'(i), v.resp, i == int'(v.len)};
      sb.push_back(b);
    end
    @(negedge ACLK);
    ARADDR = v.a; ARLEN = v.len; ARSIZE = v.sz; ARVALID = 1'b1;
    wait_sig(2, v.nm);
    @(negedge ACLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i == v.stall_b) begin
        RREADY = 1'b0;
        for (int k = 0; k < v.stall_n; k++) begin
          @(negedge ACLK);
          chk({v.nm, "_hold"}, 64'({RVALID, RLAST, RDATA}), 64'({1'b1, 1'b0, sb[0].d}));
        end
        RREADY = 1'b1;
      end
      chk_beat(v.nm);
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    chk({v.nm, "_rdone"}, 64'({RVALID, ARREADY}), 64'(2'b01));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARVALID = 1'b0; RREADY = 1'b0;
    add(1, 16'h010, 0, 2, 32'hDEADBEEF, 0, 4'hF, 0, -1, 0, 2'b00, "single_wr");
    add(0, 16'h010, 0, 2, 32'hDEADBEEF, 0, 4'h0, 0, -1, 0, 2'b00, "single_rd");
    add(1, 16'h100, 3, 2, 32'd1, 1, 4'hF, 3, -1, 0, 2'b00, "burst_wr");
    add(0, 16'h100, 3, 2, 32'd1, 1, 4'h0, 0, 1, 2, 2'b00, "burst_rd");
    add(1, 16'h020, 0, 2, 32'hFFFFFFFF, 0, 4'hF, 0, -1, 0, 2'b00, "fill_wr");
    add(1, 16'h020, 0, 2, 32'h00000000, 0, 4'h3, 0, -1, 0, 2'b00, "strb_wr");
    add(0, 16'h020, 0, 2, 32'hFFFF0000, 0, 4'h0, 0, -1, 0, 2'b00, "strb_rd");
    add(1, 16'hFF8, 1, 2, 32'hA0A0A0A0, 1, 4'hF, 1, -1, 0, 2'b00, "top_wr");
    add(1, 16'hFFC, 1, 2, 32'h55555555, 0, 4'hF, 1, -1, 0, 2'b10, "oor_wr");
    add(0, 16'hFFC, 1, 2, 32'h0, 0, 4'h0, 0, -1, 0, 2'b10, "oor_rd");
    add(0, 16'hFF8, 1, 2, 32'hA0A0A0A0, 1, 4'h0, 0, -1, 0, 2'b00, "top_rd");
    add(1, 16'h200, 1, 2, 32'h0, 0, 4'hF, 0, -1, 0, 2'b10, "early_wlast");
    add(1, 16'h204, 1, 2, 32'h0, 0, 4'hF, 5, -1, 0, 2'b10, "no_wlast");
    add(1, 16'h300, 0, 1, 32'h0, 0, 4'hF, 0, -1, 0, 2'b10, "bad_size");
    add(1, 16'h302, 0, 2, 32'h0, 0, 4'hF, 0, -1, 0, 2'b10, "misalign_wr");
    add(0, 16'h302, 0, 2, 32'h0, 0, 4'h0, 0, -1, 0, 2'b10, "misalign_rd");
    repeat (3) @(negedge ACLK);
    chk("reset_outputs", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, BRESP, RRESP, RDATA}), 64'(0));
    ARESET = 1'b0;
    #1;
    chk("reset_release", 64'({AWREADY, ARREADY}), 64'(2'b11));
    foreach (tv[i]) begin
      if (tv[i].wr) axi_write(tv[i]);
      else axi_read(tv[i]);
    end
    // same-cycle write and read of one word must return the pre-write value
    @(negedge ACLK);
    AWADDR = 16'h010; AWLEN = 0; AWSIZE = 2; AWVALID = 1'b1;
    wait_sig(0, "rbw");
    @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA = 32'h12345678; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    ARADDR = 16'h010; ARLEN = 0; ARSIZE = 2; ARVALID = 1'b1;
    sb.push_back('{32'hDEADBEEF, 2'b00, 1'b1});
    chk("rbw_ready", 64'({WREADY, ARREADY}), 64'(2'b11));
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0; RREADY = 1'b1;
    chk_beat("rbw");
    @(negedge ACLK);
    RREADY = 1'b0;
    get_b(2'b00, "rbw");
    axi_read('{0, 16'h010, 0, 2, 32'h12345678, 0, 4'h0, 0, -1, 0, 2'b00, "rbw_after"});
    @(negedge ACLK);
    AWADDR = 16'h400; AWLEN = 3; AWSIZE = 2; AWVALID = 1'b1;
    wait_sig(0, "rst_mid");
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'h11 * 32'(i + 1); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      wait_sig(1, "rst_mid");
      @(negedge ACLK);
    end
    WVALID = 1'b0;
    ARESET = 1'b1;
    #1;
    chk("rst_mid_during", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, BRESP, RRESP, RDATA}), 64'(0));
    @(negedge ACLK);
    chk("rst_mid_held", 64'({AWREADY, WREADY, BVALID}), 64'(0));
    ARESET = 1'b0;
    #1;
    chk("rst_mid_release", 64'({AWREADY, WREADY, ARREADY, BVALID}), 64'(4'b1010));
    axi_read('{0, 16'h400, 1, 2, 32'h11, 32'h11, 4'h0, 0, -1, 0, 2'b00, "rst_mid_rd"});
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
